// File: rtl/display_color_pipeline_pkg.sv
// Shared definitions for the display colour pipeline: channel ordering inside
// a segment and the MSB-first bit-replication helper used for expansion.
package display_color_pipeline_pkg;

  // Channel positions inside one segment, counted from the LSB end.
  localparam int CH_R   = 2;
  localparam int CH_G   = 1;
  localparam int CH_B   = 0;
  localparam int NUM_CH = 3;

  // Returns which input bit feeds output bit outBit when an inWidth-bit value
  // is widened to outWidth bits by repeating its bits MSB-first.
  function automatic int replSrcBit(input int outBit, input int inWidth, input int outWidth);
    return inWidth - 1 - ((outWidth - 1 - outBit) % inWidth);
  endfunction

endpackage

// File: rtl/display_color_channel.sv
// One colour channel: expansion and optional square-law gamma feeding the
// stage-1 register, brightness scaling feeding the stage-2 register. The
// parent decides when each register loads.
module display_color_channel
  import display_color_pipeline_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int CYCLEWIDTH  = 10,
  parameter int BRIGHTWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stage1En_i,
  input  logic                   stage2En_i,
  input  logic [BITWIDTH-1:0]    chan_i,
  input  logic                   gammaEn_i,
  input  logic [BRIGHTWIDTH-1:0] brightQ_i,
  output logic [CYCLEWIDTH-1:0]  chan_o
);

  localparam int SQW = 2 * CYCLEWIDTH + 1;
  localparam int PRW = CYCLEWIDTH + BRIGHTWIDTH + 1;

  logic [CYCLEWIDTH-1:0] expanded;
  logic [SQW-1:0]        square;
  logic [PRW-1:0]        product;
  logic [CYCLEWIDTH-1:0] gammaD, gammaQ;
  logic [CYCLEWIDTH-1:0] scaledD, scaledQ;

  for (genvar b = 0; b < CYCLEWIDTH; b++) begin : g_expand
    localparam int SRC = replSrcBit(b, BITWIDTH, CYCLEWIDTH);
    assign expanded[b] = chan_i[SRC];
  end

  // Stage-1 arithmetic: (e*e + e) >> C maps full scale exactly to full scale.
  always_comb begin
    square = SQW'(expanded) * SQW'(expanded) + SQW'(expanded);
    gammaD = gammaEn_i ? CYCLEWIDTH'(square >> CYCLEWIDTH) : expanded;
  end

  // Stage-2 arithmetic: scaling by (brightness + 1) keeps all-ones as unity gain.
  always_comb begin
    product = PRW'(gammaQ) * (PRW'(brightQ_i) + PRW'(1));
    scaledD = CYCLEWIDTH'(product >> BRIGHTWIDTH);
  end

  // Pipeline registers, cleared in reset so the output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gammaQ  <= '0;
      scaledQ <= '0;
    end else begin
      if (stage1En_i) gammaQ  <= gammaD;
      if (stage2En_i) scaledQ <= scaledD;
    end
  end

  assign chan_o = scaledQ;

endmodule

// File: rtl/display_color_pipeline.sv
// Two-stage valid/ready colour pipeline. Every channel of every segment runs
// through its own display_color_channel; this level owns the occupancy flags,
// the handshake and the per-word brightness that travels with stage 1.
module display_color_pipeline
  import display_color_pipeline_pkg::*;
#(
  parameter int SEGMENTS    = 2,
  parameter int BITWIDTH    = 8,
  parameter int CYCLEWIDTH  = 10,
  parameter int BRIGHTWIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [SEGMENTS*NUM_CH*BITWIDTH-1:0]   pixel,
  input  logic                               gamma_en,
  input  logic [BRIGHTWIDTH-1:0]             brightness,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SEGMENTS*NUM_CH*CYCLEWIDTH-1:0] cpixel
);

  localparam int LANES = SEGMENTS * NUM_CH;

  logic                   valid1D, valid1Q;
  logic                   valid2D, valid2Q;
  logic                   stage2Free, advance1, load1;
  logic [BRIGHTWIDTH-1:0] bright1Q;

  // Handshake and occupancy: a stage refills when empty or when it drains this cycle.
  always_comb begin
    stage2Free = !valid2Q || out_ready;
    advance1   = valid1Q && stage2Free;
    in_ready   = !valid1Q || advance1;
    load1      = in_valid && in_ready;
    valid1D    = load1 || (valid1Q && !advance1);
    valid2D    = stage2Free ? valid1Q : valid2Q;
  end

  // Valid flags and the brightness captured alongside the stage-1 word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1Q  <= 1'b0;
      valid2Q  <= 1'b0;
      bright1Q <= '0;
    end else begin
      valid1Q <= valid1D;
      valid2Q <= valid2D;
      if (load1) bright1Q <= brightness;
    end
  end

  assign out_valid = valid2Q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    display_color_channel #(
      .BITWIDTH   (BITWIDTH),
      .CYCLEWIDTH (CYCLEWIDTH),
      .BRIGHTWIDTH(BRIGHTWIDTH)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .stage1En_i(load1),
      .stage2En_i(advance1),
      .chan_i    (pixel[k*BITWIDTH +: BITWIDTH]),
      .gammaEn_i (gamma_en),
      .brightQ_i (bright1Q),
      .chan_o    (cpixel[k*CYCLEWIDTH +: CYCLEWIDTH])
    );
  end

endmodule

// File: tb/tb_display_color_pipeline.sv
// Testbench for display_color_pipeline: directed colour vectors, a randomised
// stalled stream against an arithmetic reference model, and reset behaviour.
module tb_display_color_pipeline;

  localparam int SEG = 2;
  localparam int BW  = 8;
  localparam int CW  = 10;
  localparam int BRW = 8;
  localparam int PW  = SEG * 3 * BW;
  localparam int CPW = SEG * 3 * CW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  pixel;
  logic           gamma_en;
  logic [BRW-1:0] brightness;
  logic           out_valid;
  logic           out_ready;
  logic [CPW-1:0] cpixel;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycleCount  = 0;

  typedef struct {
    logic [CPW-1:0] data;
    int             accepted;
  } entry_t;

  entry_t sb[$];

  display_color_pipeline #(
    .SEGMENTS   (SEG),
    .BITWIDTH   (BW),
    .CYCLEWIDTH (CW),
    .BRIGHTWIDTH(BRW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel     (pixel),
    .gamma_en  (gamma_en),
    .brightness(brightness),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cpixel    (cpixel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference: widen 8->10 by scaling and refilling the low bits from the top,
  // optional (e^2+e)/1024 gamma, then multiply by (brightness+1)/256.
  function automatic logic [CPW-1:0] refWord(input logic [PW-1:0] px, input logic gam,
                                             input logic [BRW-1:0] br);
    logic [CPW-1:0] w;
    int unsigned x, e, g, o;
    w = '0;
    for (int ch = 0; ch < SEG * 3; ch++) begin
      x = px[ch*BW +: BW];
      e = x * 4 + x / 64;
      g = gam ? (e * e + e) / 1024 : e;
      o = g * (br + 1) / 256;
      w[ch*CW +: CW] = o[CW-1:0];
    end
    return w;
  endfunction

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    pixel      = '0;
    gamma_en   = 1'b0;
    brightness = '0;
    #3;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    nCompared++;
    if (cpixel !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_cpixel: got %h want 0", cpixel);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_linear();
    logic [CPW-1:0] expWord;
    expWord   = {{3{10'h000}}, {3{10'h3ff}}};
    out_ready = 1'b1;
    @(negedge clk);
    pixel      = {24'h000000, 24'hffffff};
    gamma_en   = 1'b0;
    brightness = 8'hff;
    in_valid   = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL linear_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL linear_latency1: got out_valid %b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    nCompared++;
    if (out_valid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL linear_latency2: got out_valid %b want 1", out_valid);
    end
    nCompared++;
    if (cpixel !== expWord) begin
      nMismatched++;
      $display("[TB] FAIL linear_data: got %h want %h", cpixel, expWord);
    end
  endtask

  task automatic test_gamma();
    logic [CPW-1:0] expWord;
    // e = 0x202 for 0x80; (0x202*0x202 + 0x202) >> 10 = 0x102.
    expWord = {10'h102, 10'h3ff, 10'h000, 10'h000, 10'h102, 10'h3ff};
    out_ready = 1'b1;
    @(negedge clk);
    pixel      = {8'h80, 8'hff, 8'h00, 8'h00, 8'h80, 8'hff};
    gamma_en   = 1'b1;
    brightness = 8'hff;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    nCompared++;
    if (out_valid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL gamma_valid: got %b want 1", out_valid);
    end
    nCompared++;
    if (cpixel !== expWord) begin
      nMismatched++;
      $display("[TB] FAIL gamma_data: got %h want %h", cpixel, expWord);
    end
  endtask

  task automatic test_brightness();
    logic [CPW-1:0] expHalf, expZero;
    expHalf   = {6{10'h1ff}};
    expZero   = {6{10'h003}};
    out_ready = 1'b1;
    @(negedge clk);
    pixel      = {PW{1'b1}};
    gamma_en   = 1'b0;
    brightness = 8'h7f;
    in_valid   = 1'b1;
    @(negedge clk);
    brightness = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nCompared++;
    if (out_valid !== 1'b1 || cpixel !== expHalf) begin
      nMismatched++;
      $display("[TB] FAIL bright_7f: got valid %b data %h want valid 1 data %h",
               out_valid, cpixel, expHalf);
    end
    @(negedge clk);
    #1;
    nCompared++;
    if (out_valid !== 1'b1 || cpixel !== expZero) begin
      nMismatched++;
      $display("[TB] FAIL bright_00: got valid %b data %h want valid 1 data %h",
               out_valid, cpixel, expZero);
    end
  endtask

  task automatic test_bright_change();
    logic [CPW-1:0] expWord;
    expWord   = {6{10'h3ff}};
    out_ready = 1'b1;
    @(negedge clk);
    pixel      = {PW{1'b1}};
    gamma_en   = 1'b0;
    brightness = 8'hff;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    brightness = 8'h00;
    gamma_en   = 1'b1;
    @(negedge clk);
    #1;
    nCompared++;
    if (out_valid !== 1'b1 || cpixel !== expWord) begin
      nMismatched++;
      $display("[TB] FAIL bright_change: got valid %b data %h want valid 1 data %h",
               out_valid, cpixel, expWord);
    end
  endtask

  task automatic test_stream();
    int   sent;
    logic expValid, expReady, tookLast;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    sent     = 0;
    tookLast = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!in_valid || tookLast) begin
        if (sent < 8)       in_valid = 1'b1;
        else if (sent < 48) in_valid = ($urandom_range(0, 3) != 0);
        else                in_valid = 1'b0;
        pixel      = PW'({$urandom(), $urandom()});
        gamma_en   = 1'($urandom_range(0, 1));
        brightness = BRW'($urandom());
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      expValid = (sb.size() > 0) && (cycleCount - sb[0].accepted >= 2);
      expReady = !(sb.size() == 2 && !out_ready);
      nCompared++;
      if (out_valid !== expValid) begin
        nMismatched++;
        $display("[TB] FAIL stream_out_valid: got %b want %b (cycle %0d)", out_valid, expValid, cyc);
      end
      nCompared++;
      if (in_ready !== expReady) begin
        nMismatched++;
        $display("[TB] FAIL stream_in_ready: got %b want %b (cycle %0d)", in_ready, expReady, cyc);
      end
      if (expValid) begin
        nCompared++;
        if (cpixel !== sb[0].data) begin
          nMismatched++;
          $display("[TB] FAIL stream_data: got %h want %h (cycle %0d)", cpixel, sb[0].data, cyc);
        end
        if (out_ready) void'(sb.pop_front());
      end
      tookLast = in_valid && expReady;
      if (tookLast) begin
        sb.push_back('{data: refWord(pixel, gamma_en, brightness), accepted: cycleCount});
        sent++;
      end
      if (sent >= 48 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    nCompared++;
    if (sb.size() != 0 || sent < 48) begin
      nMismatched++;
      $display("[TB] FAIL stream_drain: got %0d words pending, %0d sent, want 0 pending, 48 sent",
               sb.size(), sent);
    end
  endtask

  task automatic test_reset_inflight();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready  = 1'b0;
    gamma_en   = 1'b0;
    brightness = 8'hff;
    pixel      = {PW{1'b1}};
    in_valid   = 1'b1;
    @(negedge clk);
    pixel = {PW/2{2'b10}};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nCompared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL inflight_full: got out_valid %b in_ready %b want 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL inflight_reset_valid: got %b want 0", out_valid);
    end
    nCompared++;
    if (cpixel !== '0) begin
      nMismatched++;
      $display("[TB] FAIL inflight_reset_cpixel: got %h want 0", cpixel);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL inflight_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      nCompared++;
      if (out_valid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL inflight_no_stale: got out_valid %b want 0 (cycle %0d)", out_valid, i);
      end
    end
  endtask

  // Sequence of scenarios ending with the summary line.
  initial begin
    test_reset();
    test_linear();
    test_gamma();
    test_brightness();
    test_bright_change();
    test_stream();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Guard against a run that never reaches the summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
